// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// 8N1 UART receiver, LSB first. There is no external baud tick. Every system
// clock is one oversample tick, and TICKS_PER_BIT clocks make one serial bit.
// The line is aligned to mid-bit on the start edge. Each data bit is then
// sampled once per bit period.
//
// Parameters:
//   TICKS_PER_BIT  clocks per serial bit (even, >= 4)
//   DATA_BITS      data bits per frame; d_out width
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   rx         serial line (idle high), already synchronised
//   d_out      last received byte, held until the next frame completes
//   rx_done    one-clock pulse per completed frame
//   frame_err  (only with UART_RX_FRAME_ERR_EN) stop bit sampled low on the
//              last completed frame
//
// Optional feature macro: UART_RX_FRAME_ERR_EN
// ---------------------------------------------------------------------------
module uart_rx_core #(
  parameter int TICKS_PER_BIT = 16,
  parameter int DATA_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 rx_done
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic                 frame_err
`endif
);

  localparam int SW = $clog2(TICKS_PER_BIT);
  localparam int NW = $clog2(DATA_BITS + 2);

  // State codes are fixed so they can be read directly on a debug probe.
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DESFASO = 3'd1;
  localparam logic [2:0] ESPERO  = 3'd2;
  localparam logic [2:0] RECIBO  = 3'd3;
  localparam logic [2:0] FIN     = 3'd4;

  // ESPERO ends one tick early because RECIBO supplies the last clock of
  // every bit period.
  localparam logic [SW-1:0] S_HALF_LAST = SW'(TICKS_PER_BIT / 2 - 1);
  localparam logic [SW-1:0] S_WAIT_LAST = SW'(TICKS_PER_BIT - 2);
  localparam logic [NW-1:0] N_DATA      = NW'(DATA_BITS);
  localparam logic [NW-1:0] N_STOP      = NW'(DATA_BITS + 1);

  logic [2:0]           state;
  logic [SW-1:0]        s;
  logic [NW-1:0]        n;
  logic [DATA_BITS-1:0] buffer;

  // Single sequential block: the frame state machine, its tick/bit counters,
  // the shift register and the registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      s       <= '0;
      n       <= '0;
      buffer  <= '0;
      d_out   <= '0;
      rx_done <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE: begin
          s <= '0;
          n <= '0;
          if (!rx) state <= DESFASO;
        end

        // Half a bit period moves the sampling point to the bit centres.
        // The start bit is deliberately not re-checked here.
        DESFASO: begin
          if (s == S_HALF_LAST) begin
            s     <= '0;
            state <= ESPERO;
          end else begin
            s <= s + SW'(1);
          end
        end

        // n selects what follows the wait. It is either another data bit,
        // the stop-bit centre, or the end of the stop bit.
        ESPERO: begin
          if (s == S_WAIT_LAST) begin
            s <= '0;
            if (n < N_DATA) begin
              state <= RECIBO;
            end else if (n == N_DATA) begin
              state   <= FIN;
              d_out   <= buffer;
              rx_done <= 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
              frame_err <= ~rx;
`endif
            end else begin
              state <= IDLE;
            end
          end else begin
            s <= s + SW'(1);
          end
        end

        // Bits arrive LSB first, so they shift in from the top.
        RECIBO: begin
          buffer <= {rx, buffer[DATA_BITS-1:1]};
          n      <= n + NW'(1);
          state  <= ESPERO;
        end

        // One more ESPERO pass covers the rest of the stop bit. This stops
        // a new start edge from being seen while the stop bit is still on
        // the line.
        FIN: begin
          n     <= N_STOP;
          state <= ESPERO;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_core
// Self-checking bench for uart_rx_core. The stimulus process serialises
// frames onto rx. For each frame it pushes the expected byte, the stop-bit
// error flag and the clock on which rx_done must appear. A monitor process
// pops and compares on every rx_done. On all other cycles the monitor
// checks that d_out (and frame_err when built in) hold the last completed
// frame's value. Reset forces the expected values back to zero.
// ---------------------------------------------------------------------------
module tb_uart_rx_core;

  localparam int TPB = 16;
  localparam int DB  = 8;
  // Start edge to frame completion: detect, half bit, DB full bits, then
  // the wait up to the stop-bit centre.
  localparam int FRAME_LATENCY = 1 + TPB / 2 + DB * TPB + (TPB - 1);

  typedef struct packed {
    logic [DB-1:0] data;
    logic          ferr;
    logic [31:0]   due;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          rx;
  logic [DB-1:0] d_out;
  logic          rx_done;
`ifdef UART_RX_FRAME_ERR_EN
  logic          frame_err;
`endif

  int            cyc = 0;
  logic          rst_q;
  int            checks = 0;
  int            passes = 0;
  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DB-1:0] model_dout;
  logic          model_ferr;

  uart_rx_core #(
    .TICKS_PER_BIT(TPB),
    .DATA_BITS(DB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .d_out(d_out),
    .rx_done(rx_done)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  // Free-running clock with a 10-time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter and the reset value seen at each active edge.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, actual, expected, cyc);
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    model_dout = '0;
    model_ferr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_q !== 1'b1) begin
        model_dout = '0;
        model_ferr = 1'b0;
        check_output("reset_rx_done", 32'(rx_done), 32'd0);
        check_output("reset_d_out", 32'(d_out), 32'd0);
`ifdef UART_RX_FRAME_ERR_EN
        check_output("reset_frame_err", 32'(frame_err), 32'd0);
`endif
      end else if (rx_done !== 1'b0) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_rx_done", 32'(rx_done), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("frame_d_out", 32'(d_out), 32'(mon_e.data));
          check_output("frame_timing", 32'(cyc), mon_e.due);
`ifdef UART_RX_FRAME_ERR_EN
          check_output("frame_err", 32'(frame_err), 32'(mon_e.ferr));
`endif
          model_dout = mon_e.data;
          model_ferr = mon_e.ferr;
        end
      end else begin
        check_output("d_out_hold", 32'(d_out), 32'(model_dout));
`ifdef UART_RX_FRAME_ERR_EN
        check_output("frame_err_hold", 32'(frame_err), 32'(model_ferr));
`endif
      end
    end
  end

  // Hold rx at a level for a number of clocks. The task returns just after
  // an active edge.
  task automatic drive_bit(input logic b, input int clocks);
    rx = b;
    repeat (clocks) @(posedge clk);
    #1;
  endtask

  // Send one full frame. The expected result is pushed when the frame begins.
  task automatic apply_stimulus(input logic [DB-1:0] data, input logic stop,
                                input int gap);
    exp_t e;
    e.data = data;
    e.ferr = ~stop;
    e.due  = 32'(cyc + FRAME_LATENCY);
    exp_q.push_back(e);
    drive_bit(1'b0, TPB);
    for (int i = 0; i < DB; i++) drive_bit(data[i], TPB);
    drive_bit(stop, TPB);
    drive_bit(1'b1, gap);
  endtask

  // Start a frame, then reset in the middle of data bit abort_bit. No result
  // is expected for this frame.
  task automatic apply_abort(input logic [DB-1:0] data, input int abort_bit);
    drive_bit(1'b0, TPB);
    for (int i = 0; i < abort_bit; i++) drive_bit(data[i], TPB);
    drive_bit(data[abort_bit], TPB / 2);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_bit(1'b1, 20);
  endtask

  // Stimulus: directed frames from the test plan, then random frames.
  // Gaps of at least 8 idle clocks let the receiver return to IDLE first.
  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_bit(1'b1, 20);

    apply_stimulus(8'hFF, 1'b1, 20);
    apply_stimulus(8'hA5, 1'b1, 20);
    apply_stimulus(8'h3C, 1'b1, 8);
    apply_stimulus(8'hC3, 1'b1, 20);
    apply_abort(8'h96, 4);
    apply_stimulus(8'h55, 1'b1, 20);
    apply_stimulus(8'h81, 1'b0, 20);
    apply_stimulus(8'h7E, 1'b1, 20);

    for (int k = 0; k < 12; k++) begin
      apply_stimulus(8'($urandom_range(0, 255)),
                     ($urandom_range(0, 3) != 0),
                     int'($urandom_range(8, 30)));
    end

    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    check_output("drain_pending_frames", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
